// File: rtl/sar_search_pkg.sv
// sar_search_pkg: shared constants for the successive-approximation search
// controller, its comparator and the bench.
//   SAR_WIDTH          default searched-value width
//   S_IDLE / S_SEARCH  state encodings
//   sar_state_e        enumerated state type built on those encodings
package sar_search_pkg;

  localparam int unsigned SAR_WIDTH = 4;

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_SEARCH = 1'b1;

  typedef enum logic {
    IDLE   = S_IDLE,
    SEARCH = S_SEARCH
  } sar_state_e;

endpackage

// File: rtl/sar_search_cmp_onehot_chk.sv
// cmp_onehot_chk: combinational legality check of a magnitude comparator
// response. A response is legal only when exactly one flag is high.
//   lt_i, gt_i, eq_i : comparator flags (A relative to B)
//   valid_o          : high when exactly one flag is set
module cmp_onehot_chk (
  input  logic lt_i,
  input  logic gt_i,
  input  logic eq_i,
  output logic valid_o
);

  always_comb begin
    valid_o = 1'b0;
    case ({lt_i, gt_i, eq_i})
      3'b100, 3'b010, 3'b001: valid_o = 1'b1;
      default:                valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller. Drives a trial
// value onto a comparator B input and settles one bit per clock, MSB first,
// until the comparator A-side value is recovered.
//   clk, rst_n           clock, asynchronous active-low reset
//   start_i              request a search (sampled in IDLE only)
//   cmp_lt/gt/eq_i       comparator response for the current guess_o
//   guess_o              trial value to comparator B input
//   result_o             recovered value, held until the next accepted start
//   busy_o               high while searching
//   done_o               one-cycle completion pulse (success or error)
//   err_o                illegal/inconsistent response, held until next start
//
// state  | meaning
// IDLE   | waiting for start_i; guess_o reads 0
// SEARCH | one compare sampled per edge, idx_q = bit under test
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cmp_lt_i,
  input  logic             cmp_gt_i,
  input  logic             cmp_eq_i,
  output logic [WIDTH-1:0] guess_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0]    IDX_MSB   = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] GUESS_MSB = WIDTH'(1) << (WIDTH - 1);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rsp_valid;

  cmp_onehot_chk u_chk (
    .lt_i    (cmp_lt_i),
    .gt_i    (cmp_gt_i),
    .eq_i    (cmp_eq_i),
    .valid_o (rsp_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    result_d = result_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SEARCH;
          guess_d  = GUESS_MSB;
          idx_d    = IDX_MSB;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          result_d = '0;
        end
      end
      SEARCH: begin
        if (!rsp_valid || cmp_eq_i || idx_q == '0) begin
          // Every exit path returns to IDLE with the guess cleared.
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          guess_d  = '0;
          result_d = guess_q;
          if (!rsp_valid || (!cmp_eq_i && cmp_gt_i)) begin
            // gt at bit 0 means the target lies above the all-ones prefix.
            err_d = 1'b1;
          end else if (cmp_lt_i) begin
            result_d[0] = 1'b0;
          end
        end else begin
          if (cmp_lt_i) begin
            guess_d[idx_q] = 1'b0;
          end
          guess_d[idx_q - 1'b1] = 1'b1;
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign guess_o  = guess_q;
  assign result_o = result_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller: the initiator for the team's combinational magnitude comparator. On `start` it drives a trial value `guess` onto the comparator's B side and samples the lt/gt/eq response once per clock. It settles one bit per cycle, MSB first, until it has recovered the unknown value on the comparator's A side. It sits between a control source (switch/FSM) and any WIDTH-bit comparator whose outputs are A-relative-to-B.

## Interface
- `WIDTH`, default 4: bit width of the searched value and of `guess`/`result`; legal range ≥ 2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a new search; sampled only in IDLE.
- `cmp_lt`, input, 1: comparator A_lt_B for the current `guess` (target < guess).
- `cmp_gt`, input, 1: comparator A_gt_B (target > guess).
- `cmp_eq`, input, 1: comparator A_eq_B (target == guess).
- `guess`, output, WIDTH: trial value driven to the comparator B input.
- `result`, output, WIDTH: recovered value; held from the `done` pulse until the next accepted `start`.
- `busy`, output, 1: high while in SEARCH.
- `done`, output, 1: one-cycle pulse on completion, for both success and error.
- `err`, output, 1: set with `done` on an illegal response; held until the next accepted `start`.

## Operation
- **States:** IDLE, SEARCH. Internal bit index `idx` is `$clog2(WIDTH)` bits wide.
- **IDLE + `start`:**
  - `guess <= 1 << (WIDTH-1)`, `idx <= WIDTH-1`.
  - `busy <= 1`, `err <= 0`, `result <= 0`.
  - Next state SEARCH.
- **SEARCH, per edge:** the response is valid only if exactly one of lt/gt/eq is high.
  - **`cmp_eq`:** `result <= guess`, `done <= 1`, go to IDLE (early exit).
  - **`cmp_gt` with `idx > 0`:** keep bit `idx`, set bit `idx-1`, `idx <= idx-1`.
  - **`cmp_lt` with `idx > 0`:** clear bit `idx`, set bit `idx-1`, `idx <= idx-1`.
  - **`cmp_lt` with `idx == 0`:** `result <= guess` with bit 0 cleared, `done <= 1`, go to IDLE.
  - **`cmp_gt` with `idx == 0`:** inconsistent response. `err <= 1`, `result <= guess`, `done <= 1`, go to IDLE.
  - **Not one-hot** (none set, or two or more set): abort. `err <= 1`, `result <= guess`, `done <= 1`, go to IDLE.
- **On the transition to IDLE:** `busy <= 0`, `guess <= 0`.
- **`start` while busy:** ignored, no queueing.
- **Async reset** (any time, including mid-search):
  - State IDLE; `guess`, `result`, `idx` = 0; `busy`, `done`, `err` = 0.
  - Takes effect immediately, without waiting for a clock edge.

## Timing
- **Reset values:** `guess` 0, `result` 0, `busy` 0, `done` 0, `err` 0.
- **Start:** `start` sampled at edge 0. The first `guess` and `busy` are visible after edge 0.
- **Compare sampling:** the comparator is combinational, so the response to `guess` is sampled at the next edge. Compare k (k = 1..WIDTH) is sampled at edge k.
- **Completion:** after the deciding compare k, `done` is high for exactly one cycle, and `busy` and `guess` read 0 in that same cycle.
  - Latency is k cycles: 1 minimum (eq on the first guess), WIDTH maximum.
- **Back-to-back:** `start` asserted during the `done` cycle is accepted (state is IDLE), so searches can run back to back.
- **Outputs:** all outputs are registered; no combinational path from the `cmp_*` inputs to any output.

## Structure
- **Shared package/header:**
  - State encoding localparams `S_IDLE = 1'b0`, `S_SEARCH = 1'b1`.
  - Default `WIDTH` constant, shared with the comparator and the bench.
- **Optional sub-module `cmp_onehot_chk`:** a combinational check of `cmp_lt`/`cmp_gt`/`cmp_eq`, outputting `valid` (exactly one high).
- **Bench:** pairs `sar_search` with a WIDTH-bit behavioral comparator fed by a target register.

## Test plan
All scenarios use WIDTH=4.
- **Target 11:** guesses 8(gt), 12(lt), 10(gt), 11(eq) → `done` after edge 4, `result`=11, `err`=0.
- **Target 8:** first guess 8 gives eq → `done` after edge 1, `result`=8, `busy` high for 1 cycle only.
- **Target 0:** guesses 8, 4, 2, 1, all lt → `result`=0 after edge 4, `err`=0.
- **Target 15:** guesses 8, 12, 14, 15 (gt, gt, gt, eq) → `result`=15.
  - Then assert `start` in the `done` cycle with target 3 → second search returns 3.
- **Illegal response:** force `cmp_lt`=`cmp_gt`=1 on compare 2 (`guess`=12) → `done`=1, `err`=1, `result`=12, `busy`=0.
  - Also force gt at `idx`=0 (target model mismatched) → `err`=1.
- **Reset mid-search and busy start:**
  - Drop `rst_n` after edge 2 of a search → all outputs 0 immediately, without waiting for an edge.
  - After reset release, assert `start` pulses while `busy` → ignored, and the search completes normally.
